edge_delay_meter: RTL
=====================

Name: edge_delay_meter

Overview:
- Measurement counterpart to the whole-wave delay line: it is the receive/check end of a delayed signal path.
- After a start command, measures in clk cycles the rising-edge delay and the falling-edge delay between a reference signal and its delayed echo.
- Reports both delays with timeout and ordering-error status.
- Used on the CPLD test path to verify delay stages and external loopbacks.

Parameters:
- CNT_W, 16, width of the delay counters and result outputs.
- TIMEOUT, 1000, maximum measurable delay in cycles. Must satisfy TIMEOUT < 2^CNT_W - 1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset: asynchronous, active-low.
- start  input  1  one-cycle arm request; honoured only when busy=0.
- ref_in  input  1  reference signal; asynchronous to clk.
- echo_in  input  1  delayed copy of ref_in; asynchronous to clk.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse; results are valid from this cycle.
- rise_dly  output  CNT_W  echo-rise minus ref-rise, in cycles.
- fall_dly  output  CNT_W  echo-fall minus ref-fall, in cycles.
- timeout  output  1  measurement ended by timeout; updated with done.
- order_err  output  1  echo edge arrived with no pending ref edge; updated with done.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters and synchronizers 0.
- Input conditioning: ref_in and echo_in each pass a 2-FF synchronizer plus one edge-detect register.
  - Identical path on both inputs, so synchronizer latency cancels in the measurement.
  - All edge references below mean detected edges, which lag the pins by 3 cycles.
- FSM states: IDLE, ARMED, MEASURE, REPORT.
- IDLE:
  - busy=0.
  - start=1 -> ARMED; clears timeout and order_err.
  - rise_dly and fall_dly hold their previous values until the next done.
- ARMED:
  - Waits for a ref rising edge. Echo edges in this state are ignored.
  - On ref rise, starts the rise timer (t_r) and goes to MEASURE.
  - If echo rise occurs in the same cycle, rise_dly=0 and the rise side is complete immediately.
- MEASURE: two independent sides, rise and fall. Each side is in one of three conditions: unarmed, running, or complete.
  - Rise side is armed at ARMED exit.
  - Fall side arms on the first ref fall (t_f). Later ref edges are ignored.
  - Echo rise while the rise side is running: rise_dly = t_echo - t_r; rise side complete.
  - Echo fall while the fall side is running: fall_dly = t_echo - t_f; fall side complete.
  - Echo fall in the same cycle as ref fall: fall_dly=0.
  - Echo fall while the fall side is unarmed: order_err=1 -> REPORT. Unfinished results read 0.
  - Echo rise after the rise side is complete: ignored.
  - Ref fall may precede echo rise, i.e. pulse width shorter than the delay; both sides then run concurrently.
  - Both sides complete -> REPORT.
  - A running side with elapsed delay = TIMEOUT and no echo edge: timeout=1 -> REPORT.
    - Every unfinished result reads TIMEOUT. A side that was never armed also reads TIMEOUT.
    - An echo edge arriving exactly at elapsed TIMEOUT is a valid measurement and takes priority over timeout.
- REPORT: done=1 for exactly one cycle, busy=0 from this cycle on, -> IDLE.
- Latency: done asserts 1 cycle after the completing detected edge.
- busy=1 in ARMED and MEASURE.
- start while busy is ignored. There is no abort other than rst_n.
- Counters never wrap; the TIMEOUT bound guarantees headroom.
- Reset mid-operation: immediate return to IDLE with all outputs 0. Any partial result is discarded.

Decomposition:
- Shared Verilog header holds the FSM state encodings (IDLE/ARMED/MEASURE/REPORT as 2-bit localparams) and the synchronizer depth constant (2).
- One natural sub-module: sync_edge (2-FF synchronizer plus edge detect; outputs level, rise, fall), instantiated for ref_in and echo_in.
- Per-side counter logic stays inline in the top module.

Test Plan:
- start; ref high 3 cycles; echo = ref delayed 10 cycles -> rise_dly=10, fall_dly=10, timeout=0, order_err=0, one-cycle done.
- start; ref high 2 cycles; echo = ref delayed 10 (ref falls before echo rises) -> rise_dly=10, fall_dly=10.
- start; echo tied to ref (delay 0) -> rise_dly=0, fall_dly=0, done 1 cycle after the detected fall edge.
- TIMEOUT=20; start; ref high 5 cycles; echo held 0 -> done 21 cycles after the detected ref rise, timeout=1, rise_dly=20, fall_dly=20.
- start; ref high 6 cycles; echo high 1 cycle starting 2 cycles after ref rise -> order_err=1, rise_dly=2, fall_dly=0.
- rst_n low during MEASURE -> all outputs 0 while reset is asserted.
  - Second start during busy is ignored; busy stays 1 and the results of the first run are unaffected.

Source files
------------

// File: rtl/edge_delay_meter_pkg.sv
// Shared definitions for the edge delay meter.
//   state_t    : top-level measurement FSM states
//   side_t     : condition of one measurement side (rise or fall)
//   SYNC_DEPTH : flip-flops in each input synchronizer
package edge_delay_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    MEASURE = 2'd2,
    REPORT  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SIDE_OFF  = 2'd0,
    SIDE_RUN  = 2'd1,
    SIDE_DONE = 2'd2
  } side_t;

  localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/edge_delay_meter_sync_edge.sv
// Synchronizer plus edge detector for one asynchronous input.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   pin        : asynchronous input
//   level      : synchronized level
//   rise, fall : one-cycle pulses on synchronized edges
module sync_edge
  import edge_delay_meter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_DEPTH-1:0] sync_p0;
  logic                  prev_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      prev_p1 <= 1'b0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_DEPTH-2:0], pin};
      prev_p1 <= sync_p0[SYNC_DEPTH-1];
    end
  end

  // edge-detect stage
  assign level = sync_p0[SYNC_DEPTH-1];
  assign rise  = level & ~prev_p1;
  assign fall  = ~level & prev_p1;

endmodule

// File: rtl/edge_delay_meter.sv
// Measures rising- and falling-edge delay (in clk cycles) between a
// reference signal and its delayed echo, after a start command.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   start              : one-cycle arm request, honoured when idle
//   ref_in, echo_in    : asynchronous reference and echo inputs
//   busy               : measurement in progress
//   done               : one-cycle pulse, results valid from this cycle
//   rise_dly, fall_dly : measured delays (held until the next done)
//   timeout, order_err : completion status, updated with done
module edge_delay_meter
  import edge_delay_meter_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             ref_in,
  input  logic             echo_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] rise_dly,
  output logic [CNT_W-1:0] fall_dly,
  output logic             timeout,
  output logic             order_err
);

  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  logic ref_level, ref_rise, ref_fall;
  logic echo_level, echo_rise, echo_fall;
  logic unused_levels;

  sync_edge u_ref (
    .clk   (clk),
    .rst_n (rst_n),
    .pin   (ref_in),
    .level (ref_level),
    .rise  (ref_rise),
    .fall  (ref_fall)
  );

  sync_edge u_echo (
    .clk   (clk),
    .rst_n (rst_n),
    .pin   (echo_in),
    .level (echo_level),
    .rise  (echo_rise),
    .fall  (echo_fall)
  );

  assign unused_levels = ref_level ^ echo_level;

  state_t           state;
  side_t            rise_st, fall_st;
  logic [CNT_W-1:0] cnt_r, cnt_f, rise_res, fall_res;

  // per-cycle side events, meaningful only in MEASURE
  logic             meas, rise_hit, fall_hit, fall_arm, fall_zero, order_hit;
  logic             rise_to, fall_to, rise_fin, fall_fin;
  logic [CNT_W-1:0] rise_val, fall_val;

  always_comb begin
    meas      = (state == MEASURE);
    rise_hit  = meas && (rise_st == SIDE_RUN) && echo_rise;
    fall_hit  = meas && (fall_st == SIDE_RUN) && echo_fall;
    fall_arm  = meas && (fall_st == SIDE_OFF) && ref_fall;
    fall_zero = fall_arm && echo_fall;
    // echo fall with no pending ref fall (a simultaneous ref fall is a zero delay)
    order_hit = meas && (fall_st == SIDE_OFF) && echo_fall && !ref_fall;
    // an echo edge at exactly TIMEOUT is still a valid measurement
    rise_to   = meas && (rise_st == SIDE_RUN) && !echo_rise && (cnt_r == TO_VAL);
    fall_to   = meas && (fall_st == SIDE_RUN) && !echo_fall && (cnt_f == TO_VAL);
    rise_fin  = (rise_st == SIDE_DONE) || rise_hit;
    fall_fin  = (fall_st == SIDE_DONE) || fall_hit || fall_zero;
    rise_val  = rise_hit ? cnt_r : rise_res;
    fall_val  = fall_hit ? cnt_f : (fall_zero ? '0 : fall_res);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rise_st   <= SIDE_OFF;
      fall_st   <= SIDE_OFF;
      cnt_r     <= '0;
      cnt_f     <= '0;
      rise_res  <= '0;
      fall_res  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rise_dly  <= '0;
      fall_dly  <= '0;
      timeout   <= 1'b0;
      order_err <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= ARMED;
            busy      <= 1'b1;
            timeout   <= 1'b0;
            order_err <= 1'b0;
            rise_st   <= SIDE_OFF;
            fall_st   <= SIDE_OFF;
            cnt_r     <= '0;
            cnt_f     <= '0;
            rise_res  <= '0;
            fall_res  <= '0;
          end
        end
        ARMED: begin
          // echo edges are ignored until the reference rises
          if (ref_rise) begin
            state <= MEASURE;
            if (echo_rise) begin
              rise_st <= SIDE_DONE;
            end else begin
              rise_st <= SIDE_RUN;
              cnt_r   <= ONE;
            end
          end
        end
        MEASURE: begin
          if (order_hit) begin
            state     <= REPORT;
            done      <= 1'b1;
            busy      <= 1'b0;
            order_err <= 1'b1;
            rise_dly  <= rise_fin ? rise_val : '0;
            fall_dly  <= '0;
          end else if (rise_to || fall_to) begin
            state    <= REPORT;
            done     <= 1'b1;
            busy     <= 1'b0;
            timeout  <= 1'b1;
            rise_dly <= rise_fin ? rise_val : TO_VAL;
            fall_dly <= fall_fin ? fall_val : TO_VAL;
          end else if (rise_fin && fall_fin) begin
            state    <= REPORT;
            done     <= 1'b1;
            busy     <= 1'b0;
            rise_dly <= rise_val;
            fall_dly <= fall_val;
          end else begin
            if (rise_hit) begin
              rise_st  <= SIDE_DONE;
              rise_res <= cnt_r;
            end else if (rise_st == SIDE_RUN) begin
              cnt_r <= cnt_r + ONE;
            end
            if (fall_zero) begin
              fall_st  <= SIDE_DONE;
              fall_res <= '0;
            end else if (fall_arm) begin
              fall_st <= SIDE_RUN;
              cnt_f   <= ONE;
            end else if (fall_hit) begin
              fall_st  <= SIDE_DONE;
              fall_res <= cnt_f;
            end else if (fall_st == SIDE_RUN) begin
              cnt_f <= cnt_f + ONE;
            end
          end
        end
        REPORT: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
